// File: rtl/lsu_unit_pkg.sv
// Shared types and constants for the load/store unit: op encodings, FSM states
// and byte-enable patterns.
package lsu_unit_pkg;

    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LSU_RD_W   = 5;

    // Bit 3 marks a store; bits 2:0 follow the RISC-V funct3 width/sign encoding.
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } load_store_func_code;

    typedef load_store_func_code op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } lsu_state_t;

    localparam logic [3:0] LSU_BE_NONE = 4'b0000;
    localparam logic [3:0] LSU_BE_B0   = 4'b0001;
    localparam logic [3:0] LSU_BE_LO   = 4'b0011;
    localparam logic [3:0] LSU_BE_HI   = 4'b1100;
    localparam logic [3:0] LSU_BE_W    = 4'b1111;

    function automatic logic lsu_is_store(input op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/lsu_unit_align.sv
// Combinational byte-lane logic: store lane placement with misalignment detection,
// and load-data extraction with sign/zero extension.
module lsu_unit_align
    import lsu_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  op_t               st_op_i,
    input  logic [1:0]        st_off_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              misaligned_o,
    input  op_t               ld_op_i,
    input  logic [1:0]        ld_off_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o         = LSU_BE_W;
        wdata_o      = '0;
        misaligned_o = 1'b0;
        case (st_op_i)
            SB: begin
                be_o    = LSU_BE_B0 << st_off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SH: begin
                be_o         = st_off_i[1] ? LSU_BE_HI : LSU_BE_LO;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = st_off_i[0];
            end
            SW: begin
                wdata_o      = wdata_i;
                misaligned_o = |st_off_i;
            end
            LH, LHU: misaligned_o = st_off_i[0];
            LW:      misaligned_o = |st_off_i;
            default: misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        byte_sel = rdata_i[8*ld_off_i +: 8];
        half_sel = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_op_i)
            LB:      ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     ld_data_o = {24'd0, byte_sel};
            LH:      ld_data_o = {{16{half_sel[15]}}, half_sel};
            LHU:     ld_data_o = {16'd0, half_sel};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: accepts one memory op per handshake, drives a req/gnt/rvalid data bus,
// returns load results to writeback and aborts stuck accesses after a timeout.
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  op_t               req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              stall_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    lsu_state_t        state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              we_q, we_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              data_req_q, data_req_d;
    logic              ready_q, ready_d;
    logic              stall_q, stall_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic [3:0]        al_be;
    logic [DATA_W-1:0] al_wdata;
    logic              al_mis;
    logic [DATA_W-1:0] al_ld_data;
    logic              accept;
    logic              timeout_hit;

    lsu_unit_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .st_op_i      (req_op_i),
        .st_off_i     (req_addr_i[1:0]),
        .wdata_i      (req_wdata_i),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .misaligned_o (al_mis),
        .ld_op_i      (op_q),
        .ld_off_i     (addr_q[1:0]),
        .rdata_i      (data_rdata_i),
        .ld_data_o    (al_ld_data)
    );

    assign accept      = req_valid_i && ready_q;
    assign timeout_hit = (TIMEOUT_CYC > 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    wdata_d = al_wdata;
                    be_d    = al_be;
                    we_d    = lsu_is_store(req_op_i);
                    rd_d    = req_rd_i;
                    if (al_mis) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (data_gnt_i) begin
                    // A store is complete once the bus has taken it.
                    state_d = we_q ? IDLE : WAIT_R;
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (data_rvalid_i) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = al_ld_data;
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        data_req_d = (state_d == REQ);
        stall_d    = (state_d != IDLE);
        ready_d    = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= LB;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= LSU_BE_NONE;
            we_q       <= 1'b0;
            rd_q       <= '0;
            cnt_q      <= '0;
            data_req_q <= 1'b0;
            ready_q    <= 1'b1;
            stall_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            data_req_q <= data_req_d;
            ready_q    <= ready_d;
            stall_q    <= stall_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign data_req_o   = data_req_q;
    assign data_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign misalign_o   = misalign_q;
    assign bus_err_o    = bus_err_q;
    assign stall_o      = stall_q;

endmodule
